// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
//
// Purpose: receiver FSM state encoding, the FIFO entry layout and the
// oversampling constants used by uart_rx_core and uart_rx_fifo.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // One received frame as seen by software through the DATA register.
  typedef struct packed {
    logic       perr;
    logic       ferr;
    logic [7:0] data;
  } rx_entry_t;

  localparam int OS_RATE = 16;  // ticks per bit
  localparam int OS_MID  = 7;   // tick index of the start-bit mid-point check

endpackage

// File: rtl/uart_rx_core_if.sv
// rtl/uart_rx_core_if.sv - register-map side signals of the UART receiver
//
// Purpose: bundles the register fields the receiver consumes and produces.
// Ports (master = register block, slave = uart_rx_core):
//   ctrl_baud[1:0], ctrl_rxen, lpmode_div[7:0], lpmode_en, data_rd  -> core
//   data_fifo[7:0], data_ferr, data_perr, stat_busy, stat_rxe,
//   intstat_rx, ovr_o                                                <- core
interface uart_rx_core_if;
  import uart_pkg::*;

  logic [1:0] ctrl_baud;
  logic       ctrl_rxen;
  logic [7:0] lpmode_div;
  logic       lpmode_en;
  logic       data_rd;
  logic [7:0] data_fifo;
  logic       data_ferr;
  logic       data_perr;
  logic       stat_busy;
  logic       stat_rxe;
  logic       intstat_rx;
  logic       ovr_o;

  modport master (
    output ctrl_baud, ctrl_rxen, lpmode_div, lpmode_en, data_rd,
    input  data_fifo, data_ferr, data_perr, stat_busy, stat_rxe,
           intstat_rx, ovr_o
  );

  modport slave (
    input  ctrl_baud, ctrl_rxen, lpmode_div, lpmode_en, data_rd,
    output data_fifo, data_ferr, data_perr, stat_busy, stat_rxe,
           intstat_rx, ovr_o
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous FIFO of received frames
//
// Purpose: holds rx_entry_t frames until software reads them.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears the FIFO)
//   push, pop     already qualified by the parent (no push when full
//                 unless popping, no pop when empty)
//   din           entry written on push
//   dout          head entry, all zero when empty
//   empty, full   derived from the registered entry count
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  rx_entry_t din,
  output rx_entry_t dout,
  output logic      empty,
  output logic      full
);

  localparam int AW = $clog2(DEPTH);

  rx_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;

  // Storage needs no reset: nothing is visible while the count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= r_count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign empty = (r_count == '0);
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign dout  = empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver feeding the DATA/STAT/INTSTAT fields
//
// Purpose: synchronises the RX line, oversamples at 16x, decodes 8-bit
// frames (optional even parity) and buffers them in a small FIFO.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   rx_i       asynchronous serial line, idle high
//   bus        uart_rx_core_if.slave: CTRL/LPMODE inputs, DATA read strobe,
//              FIFO head fields, busy/empty status, stored/dropped pulses
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV0       = 27,
  parameter int DIV1       = 14,
  parameter int DIV2       = 7,
  parameter int DIV3       = 4,
  parameter bit PARITY_EN  = 1'b1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx_i,
  uart_rx_core_if.slave  bus
);

  rx_state_t r_state;
  rx_state_t w_state_nxt;

  logic        r_rx_meta;
  logic        r_rx_s;
  logic        r_rx_prev;
  logic [7:0]  r_pre;
  logic [15:0] r_tick;
  logic [3:0]  r_os;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_perr;
  logic        r_push;
  rx_entry_t   r_entry;

  logic [15:0] w_div;
  logic        w_adv;
  logic        w_tick;
  logic        w_fall;
  logic        w_os_mid;
  logic        w_os_end;
  logic        w_push_nxt;
  logic        w_pop;
  logic        w_push;
  logic        w_empty;
  logic        w_full;
  rx_entry_t   w_head;

  always_comb begin
    w_div = 16'(DIV3);
    case (bus.ctrl_baud)
      2'd0:    w_div = 16'(DIV0);
      2'd1:    w_div = 16'(DIV1);
      2'd2:    w_div = 16'(DIV2);
      default: w_div = 16'(DIV3);
    endcase
  end

  // >= rather than == so a divisor or prescale lowered mid-count still
  // terminates the current period instead of running the counter around.
  assign w_adv    = !bus.lpmode_en || (r_pre >= bus.lpmode_div);
  assign w_tick   = (r_state != IDLE) && w_adv && (r_tick >= w_div - 16'd1);
  assign w_fall   = r_rx_prev && !r_rx_s;
  assign w_os_mid = (r_os == 4'(OS_MID));
  assign w_os_end = (r_os == 4'(OS_RATE - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_push_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.ctrl_rxen && w_fall) w_state_nxt = START;
      end
      START: begin
        // Line back high at mid start bit: glitch, not a frame.
        if (w_tick && w_os_mid) w_state_nxt = r_rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (w_tick && w_os_end && (r_bit == 3'd7)) begin
          w_state_nxt = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (w_tick && w_os_end) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_tick && w_os_end) begin
          w_state_nxt = IDLE;
          w_push_nxt  = bus.ctrl_rxen;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if ((r_state != IDLE) && !bus.ctrl_rxen) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
      r_pre     <= '0;
      r_tick    <= '0;
      r_os      <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
      r_push    <= 1'b0;
      r_entry   <= '0;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
      r_push    <= w_push_nxt;
      if (r_state == IDLE) begin
        // Holding everything at zero in IDLE is what reloads the
        // counters on entry to START.
        r_pre  <= '0;
        r_tick <= '0;
        r_os   <= '0;
        r_bit  <= '0;
        r_perr <= 1'b0;
      end else begin
        r_pre <= w_adv ? 8'd0 : r_pre + 8'd1;
        if (w_adv) begin
          r_tick <= w_tick ? 16'd0 : r_tick + 16'd1;
        end
        if (w_tick) begin
          if (r_state == START) begin
            r_os <= w_os_mid ? 4'd0 : r_os + 4'd1;
          end else begin
            r_os <= r_os + 4'd1;  // natural 4-bit wrap at 15
          end
          if (w_os_end) begin
            case (r_state)
              DATA: begin
                r_shift <= {r_rx_s, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
              end
              PARITY: r_perr <= r_rx_s ^ (^r_shift);
              STOP: begin
                r_entry.perr <= r_perr;
                r_entry.ferr <= !r_rx_s;
                r_entry.data <= r_shift;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  // A pop in the push cycle frees a slot, so a full FIFO still accepts.
  assign w_pop  = bus.data_rd && !w_empty;
  assign w_push = r_push && (!w_full || w_pop);

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_entry),
    .dout  (w_head),
    .empty (w_empty),
    .full  (w_full)
  );

  assign bus.data_fifo  = w_head.data;
  assign bus.data_ferr  = w_head.ferr;
  assign bus.data_perr  = w_head.perr;
  assign bus.stat_busy  = (r_state != IDLE);
  assign bus.stat_rxe   = w_empty;
  assign bus.intstat_rx = w_push;
  assign bus.ovr_o      = r_push && w_full && !w_pop;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - self-checking bench for uart_rx_core
module tb_uart_rx_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  uart_rx_core_if bus ();

  uart_rx_core dut (
    .clk  (clk),
    .rst  (rst),
    .rx_i (rx),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int irq_cyc = 0;
  int n_irq = 0;
  int n_ovr = 0;
  int exp_irq = 0;
  int exp_ovr = 0;
  int c0 = 0;
  int bp = 64;
  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.intstat_rx) begin
      n_irq   <= n_irq + 1;
      irq_cyc <= cyc;
    end
    if (bus.ovr_o) n_ovr <= n_ovr + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int div_of(input logic [1:0] b);
    case (b)
      2'd0:    return 27;
      2'd1:    return 14;
      2'd2:    return 7;
      default: return 4;
    endcase
  endfunction

  task automatic set_cfg(input logic [1:0] b, input logic en, input logic [7:0] dv);
    bus.ctrl_baud  = b;
    bus.lpmode_en  = en;
    bus.lpmode_div = dv;
    bp = 16 * div_of(b) * (en ? int'(dv) + 1 : 1);
  endtask

  // Start bit, 8 data bits LSB first, parity bit, stop bit; then idle high.
  task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb);
    logic [10:0] bits;
    bits = {sb, pb, d, 1'b0};
    @(posedge clk); #1;
    c0 = cyc;
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      repeat (bp) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  // Reference: the stop bit is sampled at its middle, 10.5 bit times after
  // the start edge, plus 3 cycles of synchronisation and push.
  task automatic frame_done(input logic [9:0] e);
    if (q.size() < 4) begin
      q.push_back(e);
      exp_irq++;
      check("latency", 32'(irq_cyc - c0), 32'(21 * bp / 2 + 3));
    end else begin
      exp_ovr++;
    end
    @(negedge clk);
    check("irq_count", 32'(n_irq), 32'(exp_irq));
    check("ovr_count", 32'(n_ovr), 32'(exp_ovr));
    check("rxe", 32'(bus.stat_rxe), 32'(q.size() == 0));
    check("head", 32'({bus.data_perr, bus.data_ferr, bus.data_fifo}),
          32'(q.size() ? q[0] : 10'd0));
  endtask

  task automatic read_one();
    @(negedge clk);
    check("rd_rxe", 32'(bus.stat_rxe), 32'(q.size() == 0));
    check("rd_head", 32'({bus.data_perr, bus.data_ferr, bus.data_fifo}),
          32'(q.size() ? q[0] : 10'd0));
    @(posedge clk); #1;
    bus.data_rd = 1'b1;
    @(posedge clk); #1;
    bus.data_rd = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  function automatic logic [9:0] entry_of(input logic [7:0] d, input logic pb, input logic sb);
    return {pb ^ (^d), ~sb, d};
  endfunction

  initial begin
    logic [7:0] d;
    logic       pb, sb, en;
    logic [1:0] b;
    logic [7:0] dv;
    int         t;

    bus.data_rd   = 1'b0;
    bus.ctrl_rxen = 1'b0;
    set_cfg(2'd3, 1'b0, 8'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_rxe", 32'(bus.stat_rxe), 32'd1);
    check("rst_busy", 32'(bus.stat_busy), 32'd0);
    check("rst_outs", 32'({bus.intstat_rx, bus.ovr_o, bus.data_perr, bus.data_ferr, bus.data_fifo}), 32'd0);
    bus.ctrl_rxen = 1'b1;

    // Basic frame and empty read
    send_frame(8'hA5, 1'b0, 1'b1);
    frame_done(entry_of(8'hA5, 1'b0, 1'b1));
    read_one();
    read_one();

    // Parity and framing errors
    send_frame(8'h01, 1'b0, 1'b0);
    frame_done(entry_of(8'h01, 1'b0, 1'b0));
    read_one();

    // False start: low for two ticks only
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (bp / 8) @(posedge clk);
    #1 rx = 1'b1;
    @(negedge clk);
    check("glitch_busy", 32'(bus.stat_busy), 32'd1);
    repeat (bp / 2 + 8) @(posedge clk);
    @(negedge clk);
    check("glitch_idle", 32'(bus.stat_busy), 32'd0);
    check("glitch_irq", 32'(n_irq), 32'(exp_irq));
    check("glitch_rxe", 32'(bus.stat_rxe), 32'd1);

    // Overflow: fifth frame dropped
    for (int v = 16; v < 21; v++) begin
      send_frame(8'(v), ^(8'(v)), 1'b1);
      frame_done(entry_of(8'(v), ^(8'(v)), 1'b1));
    end
    repeat (5) read_one();

    // Push/pop collision with a full FIFO
    for (int v = 16; v < 20; v++) begin
      send_frame(8'(v), ^(8'(v)), 1'b1);
      frame_done(entry_of(8'(v), ^(8'(v)), 1'b1));
    end
    fork
      send_frame(8'h14, ^8'h14, 1'b1);
      begin
        @(posedge clk); #1;
        t = cyc + 21 * bp / 2 + 3;
        while (cyc < t) begin
          @(posedge clk); #1;
        end
        bus.data_rd = 1'b1;
        @(posedge clk); #1;
        bus.data_rd = 1'b0;
      end
    join
    void'(q.pop_front());
    frame_done(entry_of(8'h14, ^8'h14, 1'b1));
    repeat (5) read_one();

    // Abort by dropping rxen during DATA
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (3 * bp) @(posedge clk);
    #1 bus.ctrl_rxen = 1'b0;
    @(negedge clk);
    check("abort_busy_pre", 32'(bus.stat_busy), 32'd1);
    @(negedge clk);
    check("abort_busy", 32'(bus.stat_busy), 32'd0);
    rx = 1'b1;
    repeat (12 * bp) @(posedge clk);
    @(negedge clk);
    check("abort_irq", 32'(n_irq), 32'(exp_irq));
    check("abort_rxe", 32'(bus.stat_rxe), 32'd1);
    bus.ctrl_rxen = 1'b1;

    // Low-power prescale
    set_cfg(2'd3, 1'b1, 8'd2);
    send_frame(8'h3C, ^8'h3C, 1'b1);
    frame_done(entry_of(8'h3C, ^8'h3C, 1'b1));
    check("lp_bit_period", 32'((irq_cyc - c0 - 3) * 2 / 21), 32'd192);
    read_one();

    // Randomised frames against the queue model
    for (int k = 0; k < 8; k++) begin
      b  = 2'($urandom_range(3));
      en = (b != 2'd0) && ($urandom_range(1) == 1);
      dv = 8'($urandom_range(1));
      set_cfg(b, en, dv);
      d  = 8'($urandom);
      pb = (^d) ^ ($urandom_range(3) == 0);
      sb = ($urandom_range(3) != 0);
      send_frame(d, pb, sb);
      frame_done(entry_of(d, pb, sb));
      if ($urandom_range(1) == 1) read_one();
    end

    // Reset mid-frame clears the FIFO
    set_cfg(2'd3, 1'b0, 8'd0);
    send_frame(8'h5A, ^8'h5A, 1'b1);
    frame_done(entry_of(8'h5A, ^8'h5A, 1'b1));
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (2 * bp) @(posedge clk);
    #1;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    @(negedge clk);
    check("rst_mid_busy", 32'(bus.stat_busy), 32'd0);
    check("rst_mid_rxe", 32'(bus.stat_rxe), 32'd1);
    check("rst_mid_data", 32'(bus.data_fifo), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
